// File: rtl/ex_flush_ctrl.sv
// Commit-time exception/interrupt/ertn controller: arbitrates one event, pulses the CSR
// update, holds a pipeline flush and offers a fetch redirect until fetch accepts it.
module ex_flush_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_commit_valid,
    input  logic [31:0] ws_commit_pc,
    input  logic        ex_req,
    input  logic [5:0]  ex_ecode,
    input  logic [8:0]  ex_esubcode,
    input  logic        ertn_req,
    input  logic        int_pending,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        fs_redirect_ready,
    output logic        csr_wb_ex,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_era_wvalue,
    output logic        csr_eret,
    output logic        flush_pipe,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_FLUSH    = 2'b01,
        S_REDIRECT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        K_EX   = 2'd0,
        K_INT  = 2'd1,
        K_ERTN = 2'd2
    } kind_e;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic [31:0] era_q, era_d;
    logic [31:0] target_q, target_d;
    logic        accept;

    // Events from instructions behind an in-flight flush are dropped, never queued.
    assign accept = (state_q == S_IDLE) && ws_commit_valid && (ex_req || int_pending || ertn_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            kind_q   <= K_EX;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = accept ? S_FLUSH : S_IDLE;
            S_FLUSH:    state_d = S_REDIRECT;
            S_REDIRECT: state_d = fs_redirect_ready ? S_IDLE : S_REDIRECT;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kind_d   = kind_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        target_d = target_q;
        if (accept) begin
            if (ex_req) begin
                kind_d   = K_EX;
                ecode_d  = ex_ecode;
                esub_d   = ex_esubcode;
                era_d    = ws_commit_pc;
                target_d = csr_eentry;
            end else if (int_pending) begin
                // Interrupt is taken after the committing instruction, so ERA points past it.
                kind_d   = K_INT;
                ecode_d  = 6'h00;
                esub_d   = 9'h000;
                era_d    = ws_commit_pc + 32'd4;
                target_d = csr_eentry;
            end else begin
                kind_d   = K_ERTN;
                ecode_d  = 6'h00;
                esub_d   = 9'h000;
                era_d    = 32'h0;
                target_d = csr_era;
            end
        end
    end

    always_comb begin
        csr_wb_ex      = 1'b0;
        csr_eret       = 1'b0;
        csr_ecode      = '0;
        csr_esubcode   = '0;
        csr_era_wvalue = '0;
        flush_pipe     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = 1'b0;
        case (state_q)
            S_FLUSH: begin
                busy           = 1'b1;
                flush_pipe     = 1'b1;
                csr_wb_ex      = (kind_q == K_EX) || (kind_q == K_INT);
                csr_eret       = (kind_q == K_ERTN);
                csr_ecode      = ecode_q;
                csr_esubcode   = esub_q;
                csr_era_wvalue = era_q;
            end
            S_REDIRECT: begin
                busy           = 1'b1;
                flush_pipe     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// Directed bench for ex_flush_ctrl: exception, interrupt wrap, ertn, priority,
// ignored events, redirect backpressure and reset during redirect.
module tb_ex_flush_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_commit_valid;
    logic [31:0] ws_commit_pc;
    logic        ex_req;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
    logic        ertn_req;
    logic        int_pending;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        fs_redirect_ready;
    logic        csr_wb_ex;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_era_wvalue;
    logic        csr_eret;
    logic        flush_pipe;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ex_flush_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .ws_commit_valid   (ws_commit_valid),
        .ws_commit_pc      (ws_commit_pc),
        .ex_req            (ex_req),
        .ex_ecode          (ex_ecode),
        .ex_esubcode       (ex_esubcode),
        .ertn_req          (ertn_req),
        .int_pending       (int_pending),
        .csr_eentry        (csr_eentry),
        .csr_era           (csr_era),
        .fs_redirect_ready (fs_redirect_ready),
        .csr_wb_ex         (csr_wb_ex),
        .csr_ecode         (csr_ecode),
        .csr_esubcode      (csr_esubcode),
        .csr_era_wvalue    (csr_era_wvalue),
        .csr_eret          (csr_eret),
        .flush_pipe        (flush_pipe),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .busy              (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic wbex, input logic [5:0] ec,
                           input logic [8:0] esc, input logic [31:0] era, input logic eret,
                           input logic fl, input logic rv, input logic [31:0] rpc,
                           input logic bsy);
        chk({tag, ".csr_wb_ex"},      {31'b0, csr_wb_ex},      {31'b0, wbex});
        chk({tag, ".csr_ecode"},      {26'b0, csr_ecode},      {26'b0, ec});
        chk({tag, ".csr_esubcode"},   {23'b0, csr_esubcode},   {23'b0, esc});
        chk({tag, ".csr_era_wvalue"}, csr_era_wvalue,          era);
        chk({tag, ".csr_eret"},       {31'b0, csr_eret},       {31'b0, eret});
        chk({tag, ".flush_pipe"},     {31'b0, flush_pipe},     {31'b0, fl});
        chk({tag, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, rv});
        chk({tag, ".redirect_pc"},    redirect_pc,             rpc);
        chk({tag, ".busy"},           {31'b0, busy},           {31'b0, bsy});
    endtask

    task automatic clear_ev();
        ws_commit_valid = 1'b0;
        ex_req          = 1'b0;
        ertn_req        = 1'b0;
        int_pending     = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_ev();
        ws_commit_pc      = '0;
        ex_ecode          = '0;
        ex_esubcode       = '0;
        csr_eentry        = '0;
        csr_era           = '0;
        fs_redirect_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Exception, ready tied high
        ws_commit_valid = 1'b1; ex_req = 1'b1;
        ex_ecode = 6'h0B; ex_esubcode = 9'h01A;
        ws_commit_pc = 32'h1C000100; csr_eentry = 32'h1C008000;
        tick();
        clear_ev(); ex_ecode = 6'h3F; ex_esubcode = 9'h1FF;
        chk_all("ex_flush", 1, 6'h0B, 9'h01A, 32'h1C000100, 0, 1, 0, 0, 1);
        tick();
        chk_all("ex_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C008000, 1);
        tick();
        chk_all("ex_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Interrupt with PC wrap
        ws_commit_valid = 1'b1; int_pending = 1'b1;
        ws_commit_pc = 32'hFFFFFFFC; csr_eentry = 32'h1C008000;
        tick();
        clear_ev();
        chk_all("int_flush", 1, 0, 0, 32'h00000000, 0, 1, 0, 0, 1);
        tick();
        chk_all("int_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C008000, 1);
        tick();
        chk_all("int_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ertn
        ws_commit_valid = 1'b1; ertn_req = 1'b1; csr_era = 32'h1C000204;
        ws_commit_pc = 32'h1C000500;
        tick();
        clear_ev();
        chk_all("ertn_flush", 0, 0, 0, 0, 1, 1, 0, 0, 1);
        tick();
        chk_all("ertn_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C000204, 1);
        tick();
        chk_all("ertn_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Requests without commit_valid are ignored
        ex_req = 1'b1; ertn_req = 1'b1; int_pending = 1'b1;
        tick();
        clear_ev();
        chk_all("no_commit", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // All three requests: exception wins; redirect backpressured
        ws_commit_valid = 1'b1; ex_req = 1'b1; ertn_req = 1'b1; int_pending = 1'b1;
        ex_ecode = 6'h05; ex_esubcode = 9'h003; ws_commit_pc = 32'h1C000300;
        csr_eentry = 32'h1C008000; csr_era = 32'h12345678;
        fs_redirect_ready = 1'b0;
        tick();
        clear_ev();
        chk_all("prio_flush", 1, 6'h05, 9'h003, 32'h1C000300, 0, 1, 0, 0, 1);
        tick();
        chk_all("prio_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C008000, 1);
        // New exception and EENTRY change while waiting must not disturb the redirect
        ws_commit_valid = 1'b1; ex_req = 1'b1; ex_ecode = 6'h08;
        csr_eentry = 32'hDEADBEEC; ws_commit_pc = 32'h1C000304;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("hold_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C008000, 1);
        end
        clear_ev();
        fs_redirect_ready = 1'b1;
        chk_all("handshake", 0, 0, 0, 0, 0, 1, 1, 32'h1C008000, 1);
        // Back-to-back: ertn presented in the first IDLE cycle
        tick();
        chk_all("hs_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ws_commit_valid = 1'b1; ertn_req = 1'b1; csr_era = 32'h1C000280;
        tick();
        clear_ev();
        chk_all("b2b_flush", 0, 0, 0, 0, 1, 1, 0, 0, 1);
        fs_redirect_ready = 1'b0;
        tick();
        chk_all("b2b_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C000280, 1);

        // Reset while in REDIRECT drops the redirect
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fs_redirect_ready = 1'b1;
        chk_all("rst_redir", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_all("rst_stay_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ws_commit_valid = 1'b1; ertn_req = 1'b1; csr_era = 32'h1C000400;
        tick();
        clear_ev();
        chk_all("post_rst_flush", 0, 0, 0, 0, 1, 1, 0, 0, 1);
        tick();
        chk_all("post_rst_redir", 0, 0, 0, 0, 0, 1, 1, 32'h1C000400, 1);
        tick();
        chk_all("post_rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_flush_ctrl.md
# ex_flush_ctrl

Exception and interrupt commit controller between the write-back stage, the CSR file and the fetch stage. It picks one commit-time event per cycle: a synchronous exception, an interrupt or an `ertn`. It then sequences the CSR update pulse, a multi-cycle pipeline flush and a held fetch redirect to the exception entry or return address. This makes the flush/redirect path a registered, arbitrated resource instead of ad-hoc combinational wiring from write-back.

## Interface
- No parameters. Ecode for interrupt is fixed at 6'h00.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ws_commit_valid`  in  1  an instruction completes in write-back this cycle.
- `ws_commit_pc`  in  32  PC of that instruction.
- `ex_req`  in  1  committing instruction raises an exception (qualified by `ws_commit_valid`).
- `ex_ecode`  in  6  exception code.
- `ex_esubcode`  in  9  exception subcode.
- `ertn_req`  in  1  committing instruction is `ertn` (qualified by `ws_commit_valid`).
- `int_pending`  in  1  CSR-computed pending, enabled and globally unmasked interrupt.
- `csr_eentry`  in  32  current EENTRY value.
- `csr_era`  in  32  current ERA value.
- `fs_redirect_ready`  in  1  fetch accepts the redirect this cycle.
- `csr_wb_ex`  out  1  one-cycle pulse that makes the CSR file record an exception.
- `csr_ecode`  out  6  ecode to record.
- `csr_esubcode`  out  9  esubcode to record.
- `csr_era_wvalue`  out  32  ERA value to record.
- `csr_eret`  out  1  one-cycle pulse that makes the CSR file restore PLV/IE.
- `flush_pipe`  out  1  kill all younger in-flight instructions.
- `redirect_valid`  out  1  redirect offered to fetch.
- `redirect_pc`  out  32  redirect target.
- `busy`  out  1  controller not in IDLE.

## Operation
- States: IDLE, FLUSH, REDIRECT. State is 2-bit encoded. The unused encoding returns to IDLE on the next edge.
- Event accept happens only in IDLE, and only when `ws_commit_valid`=1. Priority is exception > interrupt > ertn:
  - `ex_req`: kind=EX, ecode/esubcode from inputs, era=`ws_commit_pc`, target=`csr_eentry`.
  - else `int_pending`: kind=INT, ecode=6'h00, esubcode=0, era=`ws_commit_pc`+4 (mod 2^32), target=`csr_eentry`.
  - else `ertn_req`: kind=ERTN, target=`csr_era`.
- On accept, all fields are latched into internal registers and the state moves to FLUSH.
- FLUSH (exactly 1 cycle):
  - `flush_pipe`=1.
  - `csr_wb_ex`=1 if kind is EX or INT; `csr_eret`=1 if kind is ERTN.
  - `csr_ecode`, `csr_esubcode` and `csr_era_wvalue` are driven from the latches.
  - Next state is REDIRECT.
- REDIRECT:
  - `flush_pipe`=1, `redirect_valid`=1, `redirect_pc`=latched target.
  - The redirect is held stable until `fs_redirect_ready`=1. On that cycle the state returns to IDLE.
- `busy`=1 in FLUSH and REDIRECT.
- Events and `int_pending` presented while not in IDLE are ignored. They belong to instructions being flushed, and no queueing is done.
- Outputs `csr_ecode`, `csr_esubcode`, `csr_era_wvalue` and `redirect_pc` are 0 whenever the state does not drive them.
- `ex_req` and `ertn_req` both high: the exception is taken and the ertn is discarded.
- `ex_req`/`ertn_req`/`int_pending` with `ws_commit_valid`=0: ignored.

## Timing
- Reset: state=IDLE and all latches 0. Every output is 0 from the first cycle after the reset edge.
- Reset asserted in FLUSH or REDIRECT: IDLE on the next edge. The pending redirect is dropped and no CSR pulse is emitted.
- Accept edge T → FLUSH during T+1 → `redirect_valid` first high during T+2.
- Minimum event-to-IDLE time is 3 cycles, reached when `fs_redirect_ready`=1 in the first REDIRECT cycle.
- Back-to-back: a new event can be accepted in the first IDLE cycle after redirect completion.
- `csr_wb_ex` and `csr_eret` are each exactly one cycle wide per accepted event. They are never both high.
- `csr_eentry` and `csr_era` are sampled only at accept. Changes during FLUSH or REDIRECT do not alter `redirect_pc`.
- `flush_pipe` stays high continuously from the FLUSH cycle through the REDIRECT handshake cycle inclusive.

## Test plan
- Exception: `ws_commit_valid`=1, `ex_req`=1, ecode 6'h0B, pc 0x1C000100, eentry 0x1C008000, ready tied high.
  - → `csr_wb_ex` pulse at T+1 with era 0x1C000100.
  - → redirect to 0x1C008000 at T+2.
  - → `busy` low at T+3.
- Interrupt: `int_pending`=1 with commit pc 0xFFFFFFFC, no `ex_req`.
  - → ecode 0, `csr_era_wvalue`=0x00000000 (wrap).
  - → redirect to eentry.
- ertn: `ertn_req`=1, era 0x1C000204.
  - → `csr_eret` pulse only, no `csr_wb_ex`.
  - → redirect 0x1C000204.
- Simultaneous and ignored events: `ex_req`, `ertn_req` and `int_pending` all high → EX taken.
  - A second `ex_req` during REDIRECT is ignored.
  - Hold `fs_redirect_ready` low 4 cycles → `redirect_pc` stable, `flush_pipe` high throughout.
- Reset in REDIRECT: all outputs 0 next cycle; a following ertn is accepted normally.
